// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter: collects completed results from NUM_SRC execution units
// through per-source FIFOs. Each cycle it picks one result round-robin and
// drives it, registered, into the results buffer. The results buffer has no
// backpressure.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   flush             synchronous discard of all buffered results
//   src_valid/ready   per-source push handshake (ready from registered count)
//   src_robid/flags/  packed per-source result fields
//   src_wbs/value
//   rob_transmit      one-cycle result valid to the results buffer
//   robid/flags/wbs/  result fields; they hold their last value when idle
//   value
module rob_wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NUM_SRC-1:0]   src_valid,
  output logic [NUM_SRC-1:0]   src_ready,
  input  logic [NUM_SRC*4-1:0] src_robid,
  input  logic [NUM_SRC*8-1:0] src_flags,
  input  logic [NUM_SRC*8-1:0] src_wbs,
  input  logic [NUM_SRC*8-1:0] src_value,
  output logic                 rob_transmit,
  output logic [3:0]           robid,
  output logic [7:0]           flags,
  output logic [7:0]           wbs,
  output logic [7:0]           value
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(NUM_SRC);
  localparam int EW = 28;

  typedef logic [AW:0] ptr_t;

  logic [EW-1:0] mem [NUM_SRC][DEPTH];
  ptr_t          wr_ptr [NUM_SRC];
  ptr_t          rd_ptr [NUM_SRC];

  logic [NUM_SRC-1:0] not_empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [IW-1:0]      rr;
  logic [IW-1:0]      grant_idx;
  logic [IW-1:0]      rr_next;
  logic               grant_any;
  logic [EW-1:0]      head;

  // Occupancy is taken from registered pointers only, so a pop in the same
  // cycle never makes a full FIFO ready.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = ((wr_ptr[i] - rd_ptr[i]) != ptr_t'(DEPTH));
      not_empty[i] = (wr_ptr[i] != rd_ptr[i]);
    end
  end

  // First non-empty source at or after rr, wrapping.
  always_comb begin
    int unsigned j;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      j = (int'(rr) + k) % NUM_SRC;
      if (!grant_any && not_empty[j]) begin
        grant_any = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

  always_comb begin
    rr_next = (grant_idx == IW'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
    head    = mem[grant_idx][rd_ptr[grant_idx][AW-1:0]];
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      push[i] = src_valid[i] && src_ready[i] && !flush;
      pop[i]  = grant_any && (grant_idx == IW'(i)) && !flush;
    end
  end

  // Storage needs no reset; validity is carried by the pointers.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i][AW-1:0]] <= {src_robid[4*i +: 4], src_flags[8*i +: 8],
                                      src_wbs[8*i +: 8], src_value[8*i +: 8]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
      if (grant_any) rr <= rr_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rob_transmit <= 1'b0;
      robid        <= '0;
      flags        <= '0;
      wbs          <= '0;
      value        <= '0;
    end else if (grant_any && !flush) begin
      rob_transmit <= 1'b1;
      {robid, flags, wbs, value} <= head;
    end else begin
      rob_transmit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
module tb_rob_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [11:0] src_robid;
  logic [23:0] src_flags;
  logic [23:0] src_wbs;
  logic [23:0] src_value;
  logic        rob_transmit;
  logic [3:0]  robid;
  logic [7:0]  flags;
  logic [7:0]  wbs;
  logic [7:0]  value;

  int checks = 0;
  int errors = 0;

  rob_wb_arbiter #(.NUM_SRC(3), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_robid(src_robid), .src_flags(src_flags),
    .src_wbs(src_wbs), .src_value(src_value),
    .rob_transmit(rob_transmit), .robid(robid),
    .flags(flags), .wbs(wbs), .value(value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic [3:0] r, input logic [7:0] f,
                       input logic [7:0] w, input logic [7:0] v);
    src_robid[4*s +: 4] = r;
    src_flags[8*s +: 8] = f;
    src_wbs[8*s +: 8]   = w;
    src_value[8*s +: 8] = v;
  endtask

  task automatic do_flush();
    src_valid = '0;
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; src_valid = '0;
    src_robid = '0; src_flags = '0; src_wbs = '0; src_value = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("rst_tx", 32'(rob_transmit), 0);
    check("rst_data", {robid, flags, wbs, value}, 0);
    check("rst_ready", 32'(src_ready), 3'b111);

    // single result latency
    drive(1, 4'd5, 8'h80, 8'h32, 8'hA7);
    src_valid = 3'b010;
    step();
    src_valid = '0;
    check("lat_e1_tx", 32'(rob_transmit), 0);
    step();
    check("lat_e2_tx", 32'(rob_transmit), 1);
    check("lat_e2_data", {robid, flags, wbs, value}, {4'd5, 8'h80, 8'h32, 8'hA7});
    step();
    check("lat_e3_tx", 32'(rob_transmit), 0);
    check("lat_e3_hold", {robid, flags, wbs, value}, {4'd5, 8'h80, 8'h32, 8'hA7});

    // all three at once, rr=0
    do_flush();
    drive(0, 4'd1, 8'h01, 8'h11, 8'h21);
    drive(1, 4'd2, 8'h02, 8'h12, 8'h22);
    drive(2, 4'd3, 8'h03, 8'h13, 8'h23);
    src_valid = 3'b111;
    step();
    src_valid = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rr3_tx", 32'(rob_transmit), 1);
      check("rr3_robid", 32'(robid), k + 1);
    end
    check("rr3_value", 32'(value), 8'h23);
    step();
    check("rr3_idle", 32'(rob_transmit), 0);
    // rr back at 0: source 0 beats source 2
    drive(0, 4'd5, 8'h0, 8'h0, 8'h0);
    drive(2, 4'd4, 8'h0, 8'h0, 8'h0);
    src_valid = 3'b101;
    step();
    src_valid = '0;
    step();
    check("rr0_first", 32'(robid), 5);
    step();
    check("rr0_second", 32'(robid), 4);

    // single source streaming
    do_flush();
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        drive(0, 4'(i), 8'h0, 8'h0, 8'(i + 8'h40));
        src_valid = 3'b001;
        check("strm_ready", 32'(src_ready[0]), 1);
      end else begin
        src_valid = '0;
      end
      step();
      if (i >= 1) begin
        check("strm_tx", 32'(rob_transmit), 1);
        check("strm_robid", 32'(robid), i - 1);
      end
    end
    step();
    check("strm_end", 32'(rob_transmit), 0);

    // two sources streaming alternate
    do_flush();
    drive(0, 4'hA, 8'h0, 8'h0, 8'h0);
    drive(2, 4'hC, 8'h0, 8'h0, 8'h0);
    src_valid = 3'b101;
    step();
    check("alt_first_idle", 32'(rob_transmit), 0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("alt_tx", 32'(rob_transmit), 1);
      check("alt_robid", 32'(robid), (k % 2 == 0) ? 4'hA : 4'hC);
    end
    src_valid = '0;

    // full FIFO backpressure on source 1
    do_flush();
    drive(0, 4'd1, 8'h0, 8'h0, 8'h0);
    drive(1, 4'd2, 8'h0, 8'h0, 8'h0);
    drive(2, 4'd3, 8'h0, 8'h0, 8'h0);
    src_valid = 3'b111;
    step();
    drive(0, 4'd4, 8'h0, 8'h0, 8'h0);
    drive(1, 4'd5, 8'h0, 8'h0, 8'h0);
    src_valid = 3'b011;
    step();
    check("full_out1", 32'(robid), 1);
    check("full_ready", 32'(src_ready), 3'b101);
    drive(1, 4'd6, 8'h0, 8'h0, 8'h0);
    src_valid = 3'b010;
    step();
    check("full_out2", 32'(robid), 2);
    check("full_ready_back", 32'(src_ready), 3'b111);
    drive(1, 4'd7, 8'h0, 8'h0, 8'h0);
    step();
    src_valid = '0;
    check("full_out3", 32'(robid), 3);
    step();
    check("full_out4", 32'(robid), 4);
    step();
    check("full_out5", 32'(robid), 5);
    step();
    check("full_out7", 32'(robid), 7);
    check("full_out7_tx", 32'(rob_transmit), 1);
    step();
    check("full_drained", 32'(rob_transmit), 0);

    // flush with buffered results and a concurrent push
    do_flush();
    drive(0, 4'd1, 8'h0, 8'h0, 8'h0);
    drive(1, 4'd8, 8'h0, 8'h0, 8'h0);
    src_valid = 3'b011;
    step();
    drive(0, 4'd3, 8'h0, 8'h0, 8'h0);
    drive(2, 4'd2, 8'h0, 8'h0, 8'h0);
    src_valid = 3'b101;
    step();
    check("fl_out1", 32'(robid), 1);
    drive(0, 4'd4, 8'h0, 8'h0, 8'h0);
    src_valid = 3'b001;
    step();
    check("fl_out8", 32'(robid), 8);
    check("fl_pre_ready", 32'(src_ready), 3'b110);
    drive(1, 4'd6, 8'h0, 8'h0, 8'h0);
    src_valid = 3'b010;
    flush = 1'b1;
    step();
    flush = 1'b0;
    src_valid = '0;
    check("fl_tx", 32'(rob_transmit), 0);
    check("fl_ready", 32'(src_ready), 3'b111);
    check("fl_hold", 32'(robid), 8);
    for (int k = 0; k < 3; k++) begin
      step();
      check("fl_quiet", 32'(rob_transmit), 0);
    end

    // asynchronous reset mid-operation
    drive(0, 4'hF, 8'hFF, 8'hFF, 8'hFF);
    src_valid = 3'b001;
    step();
    step();
    check("ar_pre_tx", 32'(rob_transmit), 1);
    check("ar_pre_robid", 32'(robid), 4'hF);
    rst = 1'b1;
    #1;
    check("ar_tx", 32'(rob_transmit), 0);
    check("ar_data", {robid, flags, wbs, value}, 0);
    check("ar_ready", 32'(src_ready), 3'b111);
    src_valid = '0;
    #1 rst = 1'b0;
    step();
    check("ar_lost", 32'(rob_transmit), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
